// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard.
//
// Contents:
//   ZERO_ENTRY_IDX     index of the optional hardwired-zero entry
//   is_hardwired_zero  true when an entry index refers to the hardwired-zero
//                      entry and that feature is enabled
//
// Port priority: wherever several write ports target the same entry in one
// cycle, the lowest-indexed port wins. Both the data array and the bypass
// path follow this rule. They do so by scanning the ports from the highest
// index down to the lowest, so that the last assignment comes from the
// lowest port.
package regfile_pkg;

  localparam int ZERO_ENTRY_IDX = 0;

  function automatic logic is_hardwired_zero(input int zero_reg, input int idx);
    return (zero_reg != 0) && (idx == ZERO_ENTRY_IDX);
  endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// Per-entry busy scoreboard.
//
// Each entry has one busy flop. Its next-state priority is:
//   flush (clear)  >  alloc (set)  >  writeback (clear)  >  hold.
// When ZERO_REG is set, the hardwired-zero entry is never busy.
//
// Ports:
//   clk         clock, rising edge
//   rst_aH      asynchronous active-high reset, clears every busy bit
//   flush       clear all busy bits
//   alloc_en    per alloc port: mark alloc_addr busy
//   alloc_addr  per alloc port: entry to mark busy
//   wr_en       per write port: writeback valid
//   wr_addr     per write port: entry whose busy bit is cleared
//   busy_vec    registered busy bit per entry
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter  int N_ENTRIES     = 32,
  parameter  int N_WRITE_PORTS = 2,
  parameter  int N_ALLOC_PORTS = 2,
  parameter  int ZERO_REG      = 1,
  localparam int PTR_WIDTH     = $clog2(N_ENTRIES)
) (
  input  logic                                    clk,
  input  logic                                    rst_aH,
  input  logic                                    flush,
  input  logic [N_ALLOC_PORTS-1:0]                alloc_en,
  input  logic [N_ALLOC_PORTS-1:0][PTR_WIDTH-1:0] alloc_addr,
  input  logic [N_WRITE_PORTS-1:0]                wr_en,
  input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] wr_addr,
  output logic [N_ENTRIES-1:0]                    busy_vec
);

  logic [N_ENTRIES-1:0] set_hit;
  logic [N_ENTRIES-1:0] clr_hit;
  logic [N_ENTRIES-1:0] busy_d;

  // Decode the alloc and writeback ports into per-entry set and clear requests.
  // NOTE: every variable written in an always_comb is given a default before
  // any conditional assignment, so that no path leaves it unassigned and no
  // latch is inferred.
  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int e = 0; e < N_ENTRIES; e++) begin
      for (int a = 0; a < N_ALLOC_PORTS; a++) begin
        if (alloc_en[a] && (alloc_addr[a] == PTR_WIDTH'(e))) set_hit[e] = 1'b1;
      end
      for (int w = 0; w < N_WRITE_PORTS; w++) begin
        if (wr_en[w] && (wr_addr[w] == PTR_WIDTH'(e))) clr_hit[e] = 1'b1;
      end
    end
  end

  // An alloc beats a same-cycle writeback: the alloc is the newer producer,
  // so the entry must stay busy until that producer writes back.
  always_comb begin
    busy_d = busy_vec;
    for (int e = 0; e < N_ENTRIES; e++) begin
      if (is_hardwired_zero(ZERO_REG, e)) busy_d[e] = 1'b0;
      else if (flush)                     busy_d[e] = 1'b0;
      else if (set_hit[e])                busy_d[e] = 1'b1;
      else if (clr_hit[e])                busy_d[e] = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) busy_vec <= '0;
    else        busy_vec <= busy_d;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with an integrated busy scoreboard.
//
// Reads are combinational and return the data and the busy status of the
// addressed entry. With BYPASS set, a same-cycle writeback to the read address
// is forwarded: the read returns the written data and shows the entry as not
// busy. With ZERO_REG set, entry 0 always reads as 0 and not busy.
//
// Ports:
//   clk         clock, rising edge
//   rst_aH      asynchronous active-high reset (data and busy cleared)
//   rd_addr     per read port: entry address
//   rd_data     per read port: entry data (combinational)
//   rd_busy     per read port: entry busy status (combinational)
//   alloc_en    per alloc port: mark alloc_addr busy
//   alloc_addr  per alloc port: entry to mark busy
//   wr_en       per write port: writeback valid
//   wr_addr     per write port: writeback entry
//   wr_data     per write port: writeback data
//   flush       clear all busy bits
//   busy_vec    registered busy bit per entry
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int ENTRY_WIDTH   = 32,
  parameter  int N_ENTRIES     = 32,
  parameter  int N_READ_PORTS  = 4,
  parameter  int N_WRITE_PORTS = 2,
  parameter  int N_ALLOC_PORTS = 2,
  parameter  int BYPASS        = 1,
  parameter  int ZERO_REG      = 1,
  localparam int PTR_WIDTH     = $clog2(N_ENTRIES)
) (
  input  logic                                      clk,
  input  logic                                      rst_aH,
  input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr,
  output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data,
  output logic [N_READ_PORTS-1:0]                   rd_busy,
  input  logic [N_ALLOC_PORTS-1:0]                  alloc_en,
  input  logic [N_ALLOC_PORTS-1:0][PTR_WIDTH-1:0]   alloc_addr,
  input  logic [N_WRITE_PORTS-1:0]                  wr_en,
  input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr,
  input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
  input  logic                                      flush,
  output logic [N_ENTRIES-1:0]                      busy_vec
);

  typedef logic [PTR_WIDTH-1:0]   ptr_t;
  typedef logic [ENTRY_WIDTH-1:0] entry_t;

  entry_t               mem    [N_ENTRIES];
  logic [N_ENTRIES-1:0] wr_hit;
  entry_t               wr_sel [N_ENTRIES];

  regfile_busy_table #(
    .N_ENTRIES     (N_ENTRIES),
    .N_WRITE_PORTS (N_WRITE_PORTS),
    .N_ALLOC_PORTS (N_ALLOC_PORTS),
    .ZERO_REG      (ZERO_REG)
  ) u_busy_table (
    .clk        (clk),
    .rst_aH     (rst_aH),
    .flush      (flush),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_vec   (busy_vec)
  );

  // Select the write port for each entry. The ports are scanned from the
  // highest index down, so the lowest matching port is the last to assign and
  // wins. Writes to the hardwired-zero entry are dropped here.
  always_comb begin
    wr_hit = '0;
    for (int e = 0; e < N_ENTRIES; e++) begin
      wr_sel[e] = '0;
      if (!is_hardwired_zero(ZERO_REG, e)) begin
        for (int w = N_WRITE_PORTS - 1; w >= 0; w--) begin
          if (wr_en[w] && (wr_addr[w] == ptr_t'(e))) begin
            wr_hit[e] = 1'b1;
            wr_sel[e] = wr_data[w];
          end
        end
      end
    end
  end

  // NOTE: the data array has an asynchronous reset because every entry must
  // read 0 as soon as reset is asserted. This keeps it in flops instead of a
  // RAM macro.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int e = 0; e < N_ENTRIES; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (wr_hit[e]) mem[e] <= wr_sel[e];
      end
    end
  end

  // Read ports. The stored value is the baseline. The bypass overrides it
  // with same-cycle writeback data and shows the entry as not busy. Bypass
  // ignores allocs and flushes, which become visible one cycle later through
  // busy_vec. The zero-entry override comes last so that it also masks
  // bypassed data.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < N_READ_PORTS; r++) begin
      rd_data[r] = mem[rd_addr[r]];
      rd_busy[r] = busy_vec[rd_addr[r]];
      if (BYPASS != 0) begin
        for (int w = N_WRITE_PORTS - 1; w >= 0; w--) begin
          if (wr_en[w] && (wr_addr[w] == rd_addr[r])) begin
            rd_data[r] = wr_data[w];
            rd_busy[r] = 1'b0;
          end
        end
      end
      if (is_hardwired_zero(ZERO_REG, int'(rd_addr[r]))) begin
        rd_data[r] = '0;
        rd_busy[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters
// (32 x 32-bit entries, 4 read, 2 write and 2 alloc ports,
// BYPASS = 1, ZERO_REG = 1).
//
// Each table row drives one cycle of inputs. The bench checks read port 0
// in the middle of the cycle (combinational/bypass view), then checks
// busy_vec just after the clock edge. Hand-written sequences cover the
// asynchronous reset taken mid-cycle and the concurrent read ports.
module tb_regfile_sb;

  localparam int EW  = 32;
  localparam int NE  = 32;
  localparam int PW  = 5;
  localparam int NRP = 4;
  localparam int NWP = 2;
  localparam int NAP = 2;

  logic                     clk;
  logic                     rst_aH;
  logic [NRP-1:0][PW-1:0]   rd_addr;
  logic [NRP-1:0][EW-1:0]   rd_data;
  logic [NRP-1:0]           rd_busy;
  logic [NAP-1:0]           alloc_en;
  logic [NAP-1:0][PW-1:0]   alloc_addr;
  logic [NWP-1:0]           wr_en;
  logic [NWP-1:0][PW-1:0]   wr_addr;
  logic [NWP-1:0][EW-1:0]   wr_data;
  logic                     flush;
  logic [NE-1:0]            busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb dut (
    .clk        (clk),
    .rst_aH     (rst_aH),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  alloc_en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  wr_en;
    logic [4:0]  w0;
    logic [4:0]  w1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        flush;
    logic [4:0]  ra;
    logic [31:0] exp_data;   // rd_data[0] mid-cycle
    logic        exp_busy;   // rd_busy[0] mid-cycle
    logic [31:0] exp_bv;     // busy_vec after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic idle_inputs();
    alloc_en   = '0;
    alloc_addr = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    flush      = 1'b0;
    rd_addr    = '0;
  endtask

  initial begin
    //                alloc a0  a1  wr   w0  w1  d0            d1            fl  ra  data          busy  busy_vec
    vecs.push_back('{2'b01, 7,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  7,  32'h0,        1'b0, 32'h0000_0080}); // alloc 7
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  7,  32'h0,        1'b1, 32'h0000_0080}); // 7 busy
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  7,  32'h0,        1'b1, 32'h0000_0080});
    vecs.push_back('{2'b00, 0,  0,  2'b01, 7,  0,  32'h1234,     32'h0,        0,  7,  32'h1234,     1'b0, 32'h0000_0000}); // bypass
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  7,  32'h1234,     1'b0, 32'h0000_0000});
    vecs.push_back('{2'b00, 0,  0,  2'b11, 3,  3,  32'hAAAA,     32'hBBBB,     0,  3,  32'hAAAA,     1'b0, 32'h0000_0000}); // port 0 wins
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  3,  32'hAAAA,     1'b0, 32'h0000_0000});
    vecs.push_back('{2'b10, 0,  9,  2'b10, 0,  9,  32'h0,        32'h55,       0,  9,  32'h55,       1'b0, 32'h0000_0200}); // alloc beats wr
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  9,  32'h55,       1'b1, 32'h0000_0200});
    vecs.push_back('{2'b11, 2,  4,  2'b00, 0,  0,  32'h0,        32'h0,        0,  2,  32'h0,        1'b0, 32'h0000_0214});
    vecs.push_back('{2'b01, 6,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  4,  32'h0,        1'b1, 32'h0000_0254});
    vecs.push_back('{2'b01, 8,  0,  2'b00, 0,  0,  32'h0,        32'h0,        1,  6,  32'h0,        1'b1, 32'h0000_0000}); // flush beats alloc
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  9,  32'h55,       1'b0, 32'h0000_0000});
    vecs.push_back('{2'b01, 0,  0,  2'b01, 0,  0,  32'hFFFF,     32'h0,        0,  0,  32'h0,        1'b0, 32'h0000_0000}); // zero entry
    vecs.push_back('{2'b00, 0,  0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  0,  32'h0,        1'b0, 32'h0000_0000});
    vecs.push_back('{2'b11, 12, 12, 2'b10, 0,  12, 32'h0,        32'h77,       0,  12, 32'h77,       1'b0, 32'h0000_1000}); // dup alloc
    vecs.push_back('{2'b01, 12, 0,  2'b00, 0,  0,  32'h0,        32'h0,        0,  12, 32'h77,       1'b1, 32'h0000_1000}); // realloc busy
    vecs.push_back('{2'b00, 0,  0,  2'b11, 12, 5,  32'h99,       32'hDEADBEEF, 0,  12, 32'h99,       1'b0, 32'h0000_0000});

    // Reset state, checked while rst_aH is still asserted.
    rst_aH = 1'b1;
    idle_inputs();
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd5;
    #12;
    check("reset busy_vec", busy_vec, 32'h0);
    check("reset rd_data0", rd_data[0], 32'h0);
    check("reset rd_busy0", {31'b0, rd_busy[0]}, 32'h0);
    check("reset rd_data1", rd_data[1], 32'h0);
    rst_aH = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      alloc_en      = vecs[i].alloc_en;
      alloc_addr[0] = vecs[i].a0;
      alloc_addr[1] = vecs[i].a1;
      wr_en         = vecs[i].wr_en;
      wr_addr[0]    = vecs[i].w0;
      wr_addr[1]    = vecs[i].w1;
      wr_data[0]    = vecs[i].d0;
      wr_data[1]    = vecs[i].d1;
      flush         = vecs[i].flush;
      rd_addr       = '0;
      rd_addr[0]    = vecs[i].ra;
      #3;
      check($sformatf("vec%0d rd_data", i), rd_data[0], vecs[i].exp_data);
      check($sformatf("vec%0d rd_busy", i), {31'b0, rd_busy[0]}, {31'b0, vecs[i].exp_busy});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d busy_vec", i), busy_vec, vecs[i].exp_bv);
    end

    // Asynchronous reset mid-cycle: entry 5 holds 0xDEADBEEF and is busy.
    idle_inputs();
    alloc_en      = 2'b01;
    alloc_addr[0] = 5'd5;
    rd_addr[0]    = 5'd5;
    rd_addr[1]    = 5'd12;
    @(posedge clk);
    #1;
    alloc_en = '0;
    check("pre-rst busy_vec", busy_vec, 32'h0000_0020);
    check("pre-rst rd_data5", rd_data[0], 32'hDEADBEEF);
    check("pre-rst rd_busy5", {31'b0, rd_busy[0]}, 32'h1);
    #3;
    rst_aH = 1'b1;
    #1;
    check("async rst rd_data5", rd_data[0], 32'h0);
    check("async rst rd_busy5", {31'b0, rd_busy[0]}, 32'h0);
    check("async rst rd_data12", rd_data[1], 32'h0);
    check("async rst busy_vec", busy_vec, 32'h0);
    #2;
    rst_aH = 1'b0;
    @(posedge clk);
    #1;

    // All read ports in parallel: bypass on several ports, then stored reads.
    idle_inputs();
    wr_en      = 2'b11;
    wr_addr[0] = 5'd10;
    wr_data[0] = 32'h1010;
    wr_addr[1] = 5'd11;
    wr_data[1] = 32'h1111;
    rd_addr[0] = 5'd10;
    rd_addr[1] = 5'd11;
    rd_addr[2] = 5'd12;
    rd_addr[3] = 5'd10;
    #3;
    check("multi bypass p0", rd_data[0], 32'h1010);
    check("multi bypass p1", rd_data[1], 32'h1111);
    check("multi stored p2", rd_data[2], 32'h0);
    check("multi bypass p3", rd_data[3], 32'h1010);
    @(posedge clk);
    #1;
    wr_en      = '0;
    rd_addr[3] = 5'd11;
    #1;
    check("multi stored p0", rd_data[0], 32'h1010);
    check("multi stored p3", rd_data[3], 32'h1111);
    check("multi busy p3", {31'b0, rd_busy[3]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
